// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and bit-select helper for the SPI follower
// Purpose: FSM state encoding, frame length constants and the MISO bit picker
//          used by spi_follower. No ports.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [4:0] LEN8  = 5'd8;
    localparam logic [4:0] LEN16 = 5'd16;

    // Bit of a tx word presented on MISO for the idx-th bit of the frame.
    // MSB-first counts down from bit 7 or bit 15; LSB-first counts up from bit 0.
    function automatic logic tx_bit(input logic [15:0] w,
                                    input logic        len16,
                                    input logic        lsb_first,
                                    input logic [3:0]  idx);
        logic [3:0] pos;
        if (lsb_first) begin
            pos = idx;
        end else begin
            pos = (len16 ? 4'd15 : 4'd7) - idx;
        end
        return w[pos];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered edge detect
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   din   in  asynchronous input pin
//   sync  out synchronized level (SYNC_STAGES flops)
//   rise  out 1-cycle pulse when sync goes 0->1
//   fall  out 1-cycle pulse when sync goes 1->0
// Parameters: SYNC_STAGES (>=2) chain depth, RST_VAL level held in reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_follower.sv
// rtl/spi_follower.sv - SPI follower endpoint, CPOL/CPHA modes 0-3, 8/16-bit frames
// Purpose: oversamples leader SCLK/CS_N/MOSI in the clk domain, shifts MOSI into
//          rx_data and drives MISO from a one-word CPU tx buffer.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   cfg_cpol/cfg_cpha/cfg_len  mode and frame length, latched at cs_n fall
//   cfg_lsb_first            LSB-first order (only with SPI_FOLLOWER_LSB_FIRST_EN)
//   tx_data/tx_valid/tx_ready  tx buffer write handshake
//   rx_data/rx_valid/rx_ack  received frame, level valid, CPU acknowledge
//   rx_overrun/tx_underrun/frame_err  1-cycle status pulses
//   busy                     synchronized cs_n low
//   spi_sclk/spi_cs_n/spi_mosi  leader-driven pins
//   spi_miso/spi_miso_oe     follower data out and its output enable
// Configuration macro: SPI_FOLLOWER_LSB_FIRST_EN.
module spi_follower
    import spi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TX_IDLE     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_cpol,
    input  logic        cfg_cpha,
    input  logic        cfg_len,
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
    input  logic        cfg_lsb_first,
`endif
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        rx_overrun,
    output logic        tx_underrun,
    output logic        frame_err,
    output logic        busy,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    state_t state_q, state_d;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    logic cpol_q, cpha_q, len16_q, lsb_q, lsb_cfg;
    logic [4:0]  bitcnt, bitcnt_inc, frame_len;
    logic [15:0] tx_sh, rx_sh, tx_buf, load_word, rx_next, rx_frame;
    logic tx_full, wr;
    logic start, load, sample, drive, complete, stop, abort;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, drive_edge;
    logic eff_len16, eff_lsb;

`ifdef SPI_FOLLOWER_LSB_FIRST_EN
    assign lsb_cfg = cfg_lsb_first;
`else
    assign lsb_cfg = 1'b0;
`endif

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (spi_sclk),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk (clk), .rst (rst), .din (spi_cs_n),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI goes through the same depth as SCLK so it stays aligned with its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
        end
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // A leading edge moves SCLK away from its idle level.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_s ^ cpol_q);
    assign trail_edge  = sclk_edge & ~(sclk_s ^ cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;

    assign frame_len  = len16_q ? LEN16 : LEN8;
    assign bitcnt_inc = bitcnt + 5'd1;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        load     = 1'b0;
        sample   = 1'b0;
        drive    = 1'b0;
        complete = 1'b0;
        stop     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                    abort   = (bitcnt != 5'd0);
                end else if (sample_edge) begin
                    sample = 1'b1;
                    if (bitcnt_inc == frame_len) begin
                        complete = 1'b1;
                        load     = 1'b1;
                    end
                end else if (drive_edge) begin
                    drive = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // At frame start the latched config is not yet valid; use the live inputs.
    assign eff_len16 = start ? cfg_len : len16_q;
    assign eff_lsb   = start ? lsb_cfg : lsb_q;
    assign load_word = tx_full ? tx_buf : TX_IDLE;
    assign wr        = tx_valid & ~tx_full;
    assign rx_next   = lsb_q ? {mosi_s, rx_sh[15:1]} : {rx_sh[14:0], mosi_s};
    // LSB-first 8-bit frames accumulate in the upper byte of the shifter.
    assign rx_frame  = len16_q ? rx_next
                               : {8'h00, (lsb_q ? rx_next[15:8] : rx_next[7:0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            len16_q     <= 1'b0;
            lsb_q       <= 1'b0;
            bitcnt      <= 5'd0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            spi_miso    <= 1'b1;
        end else begin
            state_q     <= state_d;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (start) begin
                cpol_q  <= cfg_cpol;
                cpha_q  <= cfg_cpha;
                len16_q <= cfg_len;
                lsb_q   <= lsb_cfg;
                bitcnt  <= 5'd0;
                rx_sh   <= '0;
            end

            // A write landing with a load fills the buffer only after the load
            // took its old content, so the new word waits for the next frame.
            tx_full <= wr | (tx_full & ~load);
            if (wr) begin
                tx_buf <= tx_data;
            end

            if (load) begin
                tx_sh    <= load_word;
                spi_miso <= tx_bit(load_word, eff_len16, eff_lsb, 4'd0);
                if (!tx_full) begin
                    tx_underrun <= 1'b1;
                end
            end

            if (sample) begin
                rx_sh  <= rx_next;
                bitcnt <= complete ? 5'd0 : bitcnt_inc;
            end

            if (complete) begin
                rx_data    <= rx_frame;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (drive) begin
                spi_miso <= tx_bit(tx_sh, len16_q, lsb_q, bitcnt[3:0]);
            end

            if (stop) begin
                spi_miso  <= 1'b1;
                frame_err <= abort;
                bitcnt    <= 5'd0;
            end
        end
    end

    assign tx_ready    = ~tx_full;
    assign busy        = ~cs_s;
    assign spi_miso_oe = busy;

endmodule

// File: tb/tb_spi_follower.sv
// tb/tb_spi_follower.sv - directed self-checking bench for spi_follower
module tb_spi_follower;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_len = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ack = 1'b0;
    logic        rx_overrun, tx_underrun, frame_err, busy;
    logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;

    always #5 clk = ~clk;

    spi_follower #(.SYNC_STAGES(2), .TX_IDLE(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_cpol   (cfg_cpol),
        .cfg_cpha   (cfg_cpha),
        .cfg_len    (cfg_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .tx_underrun(tx_underrun),
        .frame_err  (frame_err),
        .busy       (busy),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe)
    );

    localparam logic [23:0] RESET_VEC = {1'b1, 16'h0000, 7'b0000010};

    int checks = 0;
    int errors = 0;
    int n_uf = 0, n_of = 0, n_fe = 0, n_rxv = 0;
    logic rxv_prev = 1'b0;
    logic [15:0] rxq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] outs();
        return {tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun,
                frame_err, busy, spi_miso, spi_miso_oe};
    endfunction

    // Scoreboard side: every completed frame pops the word the leader sent.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_underrun) n_uf++;
            if (rx_overrun)  n_of++;
            if (frame_err)   n_fe++;
            if ((rx_valid && !rxv_prev) || rx_overrun) begin
                check("rx_q_nonempty", 32'(rxq.size() != 0), 32'd1);
                if (rxq.size() != 0) check("rx_data", rx_data, rxq.pop_front());
            end
            if (rx_valid && !rxv_prev) n_rxv++;
        end
        rxv_prev = rx_valid;
    end

    // SCLK phase of 8 clk periods, comfortably above SYNC_STAGES+2.
    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_write(input logic [15:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic len);
        cfg_cpol = pol;
        cfg_cpha = pha;
        cfg_len  = len;
        spi_sclk = pol;
        half();
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        half();
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        half();
    endtask

    // Leader side, MSB first: sends nbits of w and returns what it captured on MISO.
    task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] got);
        int len;
        len = cfg_len ? 16 : 8;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cfg_cpha) begin
                spi_mosi = w[len-1-i];
                half();
                spi_sclk = ~cfg_cpol;
                got = {got[14:0], spi_miso};
                half();
                spi_sclk = cfg_cpol;
            end else begin
                half();
                spi_sclk = ~cfg_cpol;
                spi_mosi = w[len-1-i];
                half();
                spi_sclk = cfg_cpol;
                got = {got[14:0], spi_miso};
            end
        end
        half();
    endtask

    initial begin
        logic [15:0] got, w1, w2;
        int uf0, of0, fe0, rxv0;

        repeat (3) @(negedge clk);
        check("reset_state", outs(), RESET_VEC);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, 8-bit
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(16'h003C);
        check("a_tx_ready_full", tx_ready, 1'b0);
        rxq.push_back(16'h00A5);
        uf0 = n_uf;
        cs_low();
        check("a_busy_oe", {busy, spi_miso_oe}, 2'b11);
        check("a_tx_consumed", tx_ready, 1'b1);
        check("a_no_underrun", n_uf - uf0, 0);
        xfer(16'h00A5, 8, got);
        cs_high();
        check("a_miso", got, 16'h003C);
        check("a_rx_valid", rx_valid, 1'b1);
        check("a_idle_pins", {busy, spi_miso_oe, spi_miso}, 3'b001);
        ack();
        check("a_rx_ack", rx_valid, 1'b0);

        // Mode 3, 16-bit
        set_mode(1'b1, 1'b1, 1'b1);
        tx_write(16'h1234);
        rxq.push_back(16'hBEEF);
        cs_low();
        xfer(16'hBEEF, 16, got);
        cs_high();
        check("b_miso", got, 16'h1234);
        check("b_rx_valid", rx_valid, 1'b1);
        ack();

        // Modes 1 and 2, two 8-bit frames back-to-back under one cs_n low
        for (int m = 0; m < 2; m++) begin
            set_mode(1'(m == 1), 1'(m == 0), 1'b0);
            w1 = (m == 1) ? 16'h0096 : 16'h005A;
            w2 = (m == 1) ? 16'h000F : 16'h00C3;
            rxv0 = n_rxv;
            tx_write(16'h0011);
            cs_low();
            tx_write(16'h0022);
            rxq.push_back(w1);
            xfer(w1, 8, got);
            check("c_miso_first", got, 16'h0011);
            ack();
            rxq.push_back(w2);
            xfer(w2, 8, got);
            check("c_miso_second", got, 16'h0022);
            cs_high();
            check("c_rx_valid_rises", n_rxv - rxv0, 2);
            ack();
        end

        // cs_n rises after 5 bits
        set_mode(1'b0, 1'b0, 1'b0);
        fe0 = n_fe;
        cs_low();
        xfer(16'h00FF, 5, got);
        cs_high();
        check("d_frame_err", n_fe - fe0, 1);
        check("d_rx_valid", rx_valid, 1'b0);
        check("d_rx_data_kept", rx_data, 16'h000F);

        // Empty tx buffer at frame start
        check("e_tx_empty", tx_ready, 1'b1);
        uf0 = n_uf;
        rxq.push_back(16'h0077);
        cs_low();
        check("e_underrun_at_start", n_uf - uf0, 1);
        xfer(16'h0077, 8, got);
        cs_high();
        check("e_miso_idle_word", got, 16'h00FF);

        // Second frame without rx_ack
        check("f_rx_valid_pending", rx_valid, 1'b1);
        of0 = n_of;
        rxq.push_back(16'h0081);
        cs_low();
        xfer(16'h0081, 8, got);
        cs_high();
        check("f_overrun", n_of - of0, 1);
        check("f_rx_valid_held", rx_valid, 1'b1);
        ack();

        // Reset mid-frame
        tx_write(16'h00AA);
        cs_low();
        xfer(16'h00AA, 4, got);
        rst = 1'b1;
        #1;
        check("g_reset_mid_frame", outs(), RESET_VEC);
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        half();
        check("g_after_reset", outs(), RESET_VEC);
        check("rxq_drained", rxq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
